reg_share_arbiter: RTL
======================

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 SHALL have parameter p_nbits, default 32, data width of the shared register.
REQ-002 SHALL have parameter p_nreqs, default 4, number of requesters (legal range 2..16).
REQ-003 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_val  input  p_nreqs  per-requester valid.
REQ-006 SHALL have port req_rdy  output  p_nreqs  per-requester ready (grant).
REQ-007 SHALL have port req_msg  input  p_nreqs*p_nbits  flattened data, requester i in bits [i*p_nbits +: p_nbits].
REQ-008 SHALL have port q_val  output  1  shared register holds valid data.
REQ-009 SHALL have port q_rdy  input  1  consumer accepts q this cycle.
REQ-010 SHALL have port q  output  p_nbits  shared register contents.
REQ-011 SHALL have port q_src  output  $clog2(p_nreqs)  index of requester that wrote q.
REQ-012 SHALL have port grant_cnt  output  16  saturating count of accepted writes since reset.

Function
REQ-013 SHALL treat a transfer on either side as val && rdy in the same cycle.
REQ-014 SHALL compute accept = !q_val || q_rdy (register empty or draining this cycle).
REQ-015 SHALL keep a priority pointer ptr; winner = first i with req_val[i], searching from ptr upward, wrapping modulo p_nreqs.
REQ-016 SHALL drive req_rdy[winner] = accept, all other req_rdy bits 0, all bits 0 when no req_val is set; req_rdy combinational from req_val, q_val, q_rdy, ptr.
REQ-017 SHALL, on a granted transfer, load q <= req_msg[winner], q_src <= winner, q_val <= 1 at the next posedge (latency 1 cycle).
REQ-018 SHALL, on a granted transfer, set ptr <= (winner+1) mod p_nreqs, wrapping p_nreqs-1 to 0; ptr unchanged otherwise.
REQ-019 SHALL clear q_val when q_rdy && q_val and no grant occurs that cycle.
REQ-020 SHALL, on simultaneous drain and grant, replace q with the new data, q_val staying 1 (full throughput, one write per cycle).
REQ-021 SHALL hold q, q_src, q_val stable while q_val && !q_rdy; no req_rdy asserted then.
REQ-022 SHALL ignore req_msg of non-granted requesters; q_rdy while !q_val has no effect.
REQ-023 SHALL increment grant_cnt by 1 per granted transfer, saturating at 16'hFFFF.
REQ-024 SHALL provide a line trace under the standard trace macros in the form "<q_src>:<q>" when q_val, blank of equal width otherwise.

Reset
REQ-025 SHALL, while reset is low, force q_val=0, q=0, q_src=0, ptr=0, grant_cnt=0 asynchronously.
REQ-026 SHALL drive req_rdy all 0 while reset is low.
REQ-027 SHALL discard any held entry on reset mid-operation; first grant after release starts search at requester 0.

Structure
REQ-028 SHALL place default p_nbits, default p_nreqs and the grant_cnt width constant (16) in a shared package reg_share_pkg.
REQ-029 SHALL implement winner selection and ptr update in one sub-module reg_rr_arb (inputs req_val, ptr, en; outputs one-hot grant and winner index).
REQ-030 SHALL keep the shared register, q_val and grant_cnt in the top module only.

Verification
REQ-031 SHALL test: reset low then release with req_val=0 -> q_val=0, req_rdy=0, grant_cnt=0.
REQ-032 SHALL test: all four req_val=1 constantly, q_rdy=1, msgs 0xA0..0xA3 -> q_src sequence 0,1,2,3,0 on consecutive cycles, grant_cnt=5 after 5 grants.
REQ-033 SHALL test: req_val only on 3 after a grant to 3 (ptr wraps to 0) -> requester 3 granted again next cycle, q_src=3.
REQ-034 SHALL test: q_val=1, q_rdy=0 for 3 cycles with req_val[1]=1 -> req_rdy=0, q unchanged; q_rdy=1 in cycle 4 -> same-cycle grant to 1, q updated next edge.
REQ-035 SHALL test: reset asserted low mid-stream with q_val=1 -> q_val=0 immediately (before next clk edge), next grant goes to lowest valid index.
REQ-036 SHALL test: grant_cnt preloaded near limit by 65540 continuous grants -> grant_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/reg_share_pkg.sv
// Shared constants and helpers for the round-robin shared-register arbiter.
// Both the top and the arbitration sub-module import this package.
package reg_share_pkg;

  localparam int P_NBITS_DEF = 32;
  localparam int P_NREQS_DEF = 4;
  localparam int GRANT_CNT_W = 16;

  // (base + off) mod n, for base < n and off < n
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/reg_rr_arb.sv
// Round-robin winner search starting at ptr, plus the next-pointer value.
// The search is purely combinational; the pointer register lives in the top.
module reg_rr_arb
  import reg_share_pkg::*;
#(
  parameter int p_nreqs = P_NREQS_DEF,
  parameter int p_idx_w = $clog2(p_nreqs)
) (
  input  logic [p_nreqs-1:0]  req_val,
  input  logic [p_idx_w-1:0]  ptr,
  input  logic                en,
  output logic [p_nreqs-1:0]  grant,
  output logic [p_idx_w-1:0]  winner,
  output logic [p_idx_w-1:0]  ptr_nxt
);

  logic               found;
  logic [p_idx_w-1:0] idx;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    idx     = '0;
    grant   = '0;
    ptr_nxt = ptr;
    for (int off = 0; off < p_nreqs; off++) begin
      idx = p_idx_w'(wrap_add(int'(ptr), off, p_nreqs));
      if (!found && req_val[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (found && en) begin
      grant[winner] = 1'b1;
      ptr_nxt       = p_idx_w'(wrap_add(int'(winner), 1, p_nreqs));
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// N requesters share one output register; round-robin grant, one write per
// cycle, with back-pressure from the consumer and a saturating grant counter.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int p_nbits = P_NBITS_DEF,
  parameter int p_nreqs = P_NREQS_DEF,
  parameter int p_idx_w = $clog2(p_nreqs)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [p_nreqs-1:0]           req_val,
  output logic [p_nreqs-1:0]           req_rdy,
  input  logic [p_nreqs*p_nbits-1:0]   req_msg,
  output logic                         q_val,
  input  logic                         q_rdy,
  output logic [p_nbits-1:0]           q,
  output logic [p_idx_w-1:0]           q_src,
  output logic [GRANT_CNT_W-1:0]       grant_cnt
);

  logic               accept;
  logic               do_grant;
  logic [p_nreqs-1:0] grant;
  logic [p_idx_w-1:0] winner;
  logic [p_idx_w-1:0] ptr;
  logic [p_idx_w-1:0] ptr_nxt;
  logic [p_nbits-1:0] win_msg;

  assign accept = !q_val || q_rdy;

  reg_rr_arb #(
    .p_nreqs (p_nreqs),
    .p_idx_w (p_idx_w)
  ) u_arb (
    .req_val (req_val),
    .ptr     (ptr),
    .en      (accept),
    .grant   (grant),
    .winner  (winner),
    .ptr_nxt (ptr_nxt)
  );

  // Grants are masked while reset is held so no requester sees a handshake.
  assign req_rdy  = reset ? grant : '0;
  assign do_grant = |req_rdy;

  always_comb begin
    win_msg = '0;
    for (int i = 0; i < p_nreqs; i++)
      if (winner == p_idx_w'(i)) win_msg = req_msg[i*p_nbits +: p_nbits];
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; reset is asynchronous and clears all state immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_val     <= 1'b0;
      q         <= '0;
      q_src     <= '0;
      ptr       <= '0;
      grant_cnt <= '0;
    end else begin
      if (do_grant) begin
        q_val <= 1'b1;
        q     <= win_msg;
        q_src <= winner;
        ptr   <= ptr_nxt;
        if (grant_cnt != '1) grant_cnt <= grant_cnt + 1'b1;
      end else if (q_rdy) begin
        q_val <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  // "<q_src>:<q>" in hex when q_val, spaces of the same width otherwise.
  function automatic string line_trace();
    string s;
    string b;
    s = $sformatf("%x:%x", q_src, q);
    if (!q_val) begin
      b = "";
      for (int i = 0; i < s.len(); i++) b = {b, " "};
      s = b;
    end
    return s;
  endfunction
`endif

endmodule
